// File: rtl/adder_axi_master.sv
// AXI-lite style master: writes two operands to the adder slave,
// reads back the sum, and reports it with a one-cycle done strobe.
module adder_axi_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_SIZE = 8,
  parameter logic [ADDRESS_SIZE-1:0] ADDR_A   = 8'h00,
  parameter logic [ADDRESS_SIZE-1:0] ADDR_B   = 8'h04,
  parameter logic [ADDRESS_SIZE-1:0] ADDR_SUM = 8'h08
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    error,
  output logic [ADDRESS_SIZE-1:0] AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic                    WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic                    BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDRESS_SIZE-1:0] ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic                    RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  typedef enum logic [2:0] {
    IDLE, WR_A, RESP_A, WR_B,
    RESP_B, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   opb;
  logic                    err_acc;
  logic                    aw_ok;
  logic                    w_ok;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    aw_fin;
  logic                    w_fin;

  assign WSTRB  = 1'b1;
  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  // AW and W finish independently; either may land first
  assign aw_fin = aw_ok | aw_hs;
  assign w_fin  = w_ok | w_hs;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      opb     <= '0;
      err_acc <= 1'b0;
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      result  <= '0;
      AWADDR  <= '0;
      AWVALID <= 1'b0;
      WDATA   <= '0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      ARADDR  <= '0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opb     <= op_b;
            err_acc <= 1'b0;
            busy    <= 1'b1;
            AWADDR  <= ADDR_A;
            WDATA   <= op_a;
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
            state   <= WR_A;
          end
        end
        WR_A, WR_B: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_ok   <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_ok   <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            BREADY <= 1'b1;
            state  <= (state == WR_A) ? RESP_A : RESP_B;
          end
        end
        RESP_A: begin
          if (BVALID) begin
            BREADY  <= 1'b0;
            err_acc <= err_acc | BRESP;
            AWADDR  <= ADDR_B;
            WDATA   <= opb;
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
            state   <= WR_B;
          end
        end
        RESP_B: begin
          if (BVALID) begin
            BREADY  <= 1'b0;
            err_acc <= err_acc | BRESP;
            ARADDR  <= ADDR_SUM;
            ARVALID <= 1'b1;
            state   <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (RVALID) begin
            RREADY  <= 1'b0;
            result  <= RDATA;
            err_acc <= err_acc | RRESP;
            error   <= err_acc | RRESP;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_axi_master.sv
// Directed bench for adder_axi_master against a behavioural
// adder slave with per-channel wait-cycle knobs.
module tb_adder_axi_master;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic          busy, done, error;
  logic [DW-1:0] result;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic          WSTRB, WVALID, WREADY;
  logic          BRESP, BVALID, BREADY;
  logic          ARVALID, ARREADY;
  logic          RRESP, RVALID, RREADY;

  adder_axi_master dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .op_a(op_a), .op_b(op_b), .busy(busy),
    .done(done), .result(result), .error(error),
    .AWADDR(AWADDR), .AWVALID(AWVALID),
    .AWREADY(AWREADY), .WDATA(WDATA),
    .WSTRB(WSTRB), .WVALID(WVALID),
    .WREADY(WREADY), .BRESP(BRESP),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RVALID(RVALID),
    .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // slave knobs and state
  int            aw_d = 0, w_d = 0, b_d = 0;
  int            ar_d = 0, r_d = 0;
  logic          binj = 1'b0;
  int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic [DW-1:0] reg_a, reg_b, wd;
  logic [AW-1:0] wa;
  logic          got_aw, got_w, b_pend, bresp_q, r_pend;
  int            wr_cnt = 0, rd_cnt = 0;
  int            done_cnt = 0, viol = 0;
  logic          aw_hs, w_hs;
  logic [AW-1:0] a_sel;
  logic [DW-1:0] d_sel;

  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign a_sel   = aw_hs ? AWADDR : wa;
  assign d_sel   = w_hs ? WDATA : wd;
  assign AWREADY = (aw_cnt >= aw_d);
  assign WREADY  = (w_cnt >= w_d);
  assign ARREADY = (ar_cnt >= ar_d);
  assign BVALID  = b_pend && (b_cnt >= b_d);
  assign BRESP   = BVALID & bresp_q;
  assign RVALID  = r_pend && (r_cnt >= r_d);
  assign RDATA   = RVALID ? reg_a + reg_b : 32'hDEADBEEF;
  assign RRESP   = 1'b0;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      b_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      b_pend <= 1'b0; bresp_q <= 1'b0;
      r_pend <= 1'b0;
      wa <= '0; wd <= '0;
      reg_a <= '0; reg_b <= '0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
      if (aw_hs) begin wa <= AWADDR; got_aw <= 1'b1; end
      if (w_hs) begin wd <= WDATA; got_w <= 1'b1; end
      if (b_pend) begin
        if (BVALID && BREADY) b_pend <= 1'b0;
        else if (!BVALID) b_cnt <= b_cnt + 1;
      end
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        if (a_sel == 8'h00) reg_a <= d_sel;
        else if (a_sel == 8'h04) reg_b <= d_sel;
        got_aw  <= 1'b0;
        got_w   <= 1'b0;
        b_pend  <= 1'b1;
        b_cnt   <= 0;
        bresp_q <= binj && (a_sel == 8'h04);
        wr_cnt  <= wr_cnt + 1;
      end
      if (ARVALID && ARREADY) begin
        r_pend <= 1'b1;
        r_cnt  <= 0;
        rd_cnt <= rd_cnt + 1;
      end else if (r_pend) begin
        if (RVALID && RREADY) r_pend <= 1'b0;
        else if (!RVALID) r_cnt <= r_cnt + 1;
      end
    end
  end

  always @(posedge ACLK) if (done) done_cnt <= done_cnt + 1;

  // AXI stability: valid+payload held until handshake, one beat per write
  logic          aw_hold, w_hold, ar_hold;
  logic [AW-1:0] aw_p, ar_p;
  logic [DW-1:0] w_p;
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
    end else begin
      viol <= viol
        + int'(aw_hold && (!AWVALID || AWADDR != aw_p))
        + int'(w_hold && (!WVALID || WDATA != w_p))
        + int'(ar_hold && (!ARVALID || ARADDR != ar_p))
        + int'(aw_hs && got_aw) + int'(w_hs && got_w);
      aw_hold <= AWVALID && !AWREADY;
      w_hold  <= WVALID && !WREADY;
      ar_hold <= ARVALID && !ARREADY;
      aw_p <= AWADDR; w_p <= WDATA; ar_p <= ARADDR;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input logic [DW-1:0] a,
                         input logic [DW-1:0] b,
                         output int lat,
                         output logic [DW-1:0] res,
                         output logic err,
                         output logic pulse_ok,
                         output logic busy0);
    @(negedge ACLK);
    op_a = a; op_b = b; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge ACLK);
      lat++;
    end
    res = result;
    err = error;
    @(negedge ACLK);
    pulse_ok = !done;
  endtask

  typedef struct {
    logic [DW-1:0] a, b;
    int            awd, wdl, bd, ard, rd;
    logic          inj;
    logic [DW-1:0] sum;
    logic          err;
    int            lat;
  } vec_t;

  vec_t          v[6];
  int            lat, w0, r0, d0;
  logic [DW-1:0] res;
  logic          err, pok, bz;

  initial begin
    v[0] = '{32'd5, 32'd7, 0, 0, 0, 0, 0, 1'b0, 32'd12, 1'b0, 6};
    v[1] = '{32'd100, 32'd23, 3, 0, 0, 0, 0, 1'b0, 32'd123, 1'b0, 12};
    v[2] = '{32'hFFFFFFF0, 32'hF, 0, 0, 0, 0, 0, 1'b1,
             32'hFFFFFFFF, 1'b1, 6};
    v[3] = '{32'd1, 32'd1, 0, 0, 0, 0, 0, 1'b0, 32'd2, 1'b0, 6};
    v[4] = '{32'h1000, 32'h234, 0, 0, 0, 0, 5, 1'b0,
             32'h1234, 1'b0, 11};
    v[5] = '{32'd40, 32'd2, 0, 1, 1, 2, 0, 1'b0, 32'd42, 1'b0, 12};

    #1 ARESET = 1'b1;
    #1;
    check("rst_busy_done_err", {61'd0, busy, done, error}, 64'd0);
    check("rst_valids",
          {58'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, 1'b0},
          64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_addr_data", {16'd0, AWADDR, ARADDR, WDATA}, 64'd0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;

    for (int i = 0; i < 6; i++) begin
      aw_d = v[i].awd; w_d = v[i].wdl; b_d = v[i].bd;
      ar_d = v[i].ard; r_d = v[i].rd; binj = v[i].inj;
      w0 = wr_cnt; r0 = rd_cnt;
      run_txn(v[i].a, v[i].b, lat, res, err, pok, bz);
      check($sformatf("v%0d_result", i), 64'(res), 64'(v[i].sum));
      check($sformatf("v%0d_error", i), 64'(err), 64'(v[i].err));
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].lat));
      check($sformatf("v%0d_single_pulse", i), 64'(pok), 64'd1);
      check($sformatf("v%0d_busy", i), 64'(bz), 64'd1);
      check($sformatf("v%0d_wdata_a", i), 64'(reg_a), 64'(v[i].a));
      check($sformatf("v%0d_wdata_b", i), 64'(reg_b), 64'(v[i].b));
      check($sformatf("v%0d_writes", i), 64'(wr_cnt - w0), 64'd2);
      check($sformatf("v%0d_reads", i), 64'(rd_cnt - r0), 64'd1);
      check($sformatf("v%0d_idle", i), 64'(busy), 64'd0);
    end
    aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; binj = 1'b0;

    // start held high for 10 edges: one txn per IDLE visit
    d0 = done_cnt; r0 = rd_cnt;
    @(negedge ACLK);
    op_a = 32'd3; op_b = 32'd4; start = 1'b1;
    repeat (10) @(negedge ACLK);
    start = 1'b0;
    repeat (20) @(negedge ACLK);
    check("held_done_count", 64'(done_cnt - d0), 64'd2);
    check("held_read_count", 64'(rd_cnt - r0), 64'd2);
    check("held_result", 64'(result), 64'd7);

    // start pulsed during busy, operands changed mid-flight
    d0 = done_cnt; r0 = rd_cnt;
    @(negedge ACLK);
    op_a = 32'd10; op_b = 32'd20; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge ACLK);
      op_a = 32'd99; op_b = 32'd99;
      start = (k % 2 == 0);
    end
    @(negedge ACLK);
    start = 1'b0;
    repeat (20) @(negedge ACLK);
    check("pulse_done_count", 64'(done_cnt - d0), 64'd1);
    check("pulse_read_count", 64'(rd_cnt - r0), 64'd1);
    check("pulse_wdata_a", 64'(reg_a), 64'd10);
    check("pulse_wdata_b", 64'(reg_b), 64'd20);
    check("pulse_result", 64'(result), 64'd30);

    // reset while ARVALID is pending
    ar_d = 20;
    @(negedge ACLK);
    op_a = 32'd8; op_b = 32'd9; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    lat = 0;
    while (!ARVALID && lat < 50) begin
      @(negedge ACLK);
      lat++;
    end
    check("arvalid_seen", 64'(ARVALID), 64'd1);
    #1 ARESET = 1'b1;
    #1;
    check("arst_arvalid", 64'(ARVALID), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_outs",
          {56'd0, AWVALID, WVALID, BREADY, RREADY, done, error,
           2'b00}, 64'd0);
    check("arst_araddr", 64'(ARADDR), 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    ar_d = 0;
    run_txn(32'h11, 32'h22, lat, res, err, pok, bz);
    check("post_rst_result", 64'(res), 64'h33);
    check("post_rst_latency", 64'(lat), 64'd6);
    check("post_rst_error", 64'(err), 64'd0);

    repeat (2) @(negedge ACLK);
    check("axi_stability", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
